// File: rtl/lcd_clock_pkg.sv
// Shared constants for the lcd_show_time sequencer.
//   - Font indices (ASCII code minus 0x20) for space, dash, digit 0 and colon.
//   - Character pitches for the 12x6 and 16x8 fonts.
//   - Sequencer FSM state encoding and the number of characters per frame.
package lcd_clock_pkg;

  localparam logic [6:0] FONT_SPACE  = 7'd0;
  localparam logic [6:0] FONT_DASH   = 7'd13;
  localparam logic [6:0] FONT_DIGIT0 = 7'd16;
  localparam logic [6:0] FONT_COLON  = 7'd26;

  localparam logic [8:0] PITCH_SMALL = 9'd6;
  localparam logic [8:0] PITCH_LARGE = 9'd8;

  localparam int unsigned CHAR_NUM = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWait,
    StNext,
    StFdone
  } state_e;

  function automatic logic [6:0] digit_font(logic [3:0] d);
    return FONT_DIGIT0 + {3'b000, d};
  endfunction

endpackage

// File: rtl/lcd_show_time_if.sv
// Handshake bus between the time sequencer (master) and the lcd_show_char
// renderer (slave).
//   show_char_flag : single-cycle start pulse to the renderer
//   ascii_num      : font index of the character to draw
//   start_x/start_y: top-left pixel of the character
//   en_size        : font select (1 = 16x8, 0 = 12x6)
//   show_char_done : single-cycle completion pulse from the renderer
interface lcd_show_time_if;
  logic       show_char_flag;
  logic [6:0] ascii_num;
  logic [8:0] start_x;
  logic [8:0] start_y;
  logic       en_size;
  logic       show_char_done;

  modport master (
    output show_char_flag,
    output ascii_num,
    output start_x,
    output start_y,
    output en_size,
    input  show_char_done
  );

  modport slave (
    input  show_char_flag,
    input  ascii_num,
    input  start_x,
    input  start_y,
    input  en_size,
    output show_char_done
  );
endinterface

// File: rtl/bin2dec_2d.sv
// Combinational two-digit binary-to-decimal splitter.
//   bin_i  : binary value, 0..127
//   tens_o : decimal tens digit
//   ones_o : decimal ones digit
//   oor_o  : high when bin_i exceeds MAX (digits are then meaningless)
module bin2dec_2d #(
  parameter int unsigned MAX = 59
) (
  input  logic [6:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       oor_o
);

  always_comb begin
    tens_o = 4'(bin_i / 7'd10);
    ones_o = 4'(bin_i % 7'd10);
    oor_o  = 32'(bin_i) > MAX;
  end

endmodule

// File: rtl/lcd_show_time.sv
// Sequencer that draws the current time as "HH:MM:SS" through lcd_show_char.
// A refresh request snapshots hour/minute/second into an 8-character buffer,
// then issues one character at a time, waiting for the renderer's done pulse
// between characters. Requests arriving mid-frame merge into a 1-deep pending
// flag that triggers exactly one further frame.
//   sys_clk, sys_rst      : clock, asynchronous active-high reset
//   refresh_req           : single-cycle redraw request
//   hour, minute, second  : binary time fields
//   lcd                   : renderer handshake bus (master side)
//   busy                  : high from LOAD through FDONE
//   frame_done            : single-cycle pulse when the frame is complete
// Optional feature: define LCD_CLOCK_BLINK_COLON_EN to blank both colons
// whenever the snapshotted second is odd.
module lcd_show_time
  import lcd_clock_pkg::*;
#(
  parameter logic [8:0] X0         = 9'd16,
  parameter logic [8:0] Y0         = 9'd56,
  parameter bit         FONT_LARGE = 1'b1
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            refresh_req,
  input  logic [4:0]      hour,
  input  logic [5:0]      minute,
  input  logic [5:0]      second,
  lcd_show_time_if.master lcd,
  output logic            busy,
  output logic            frame_done
);

  localparam logic [8:0] Pitch   = FONT_LARGE ? PITCH_LARGE : PITCH_SMALL;
  localparam logic [2:0] LastIdx = 3'(CHAR_NUM - 1);

  state_e     state_q, state_d;
  logic       pending_q, pending_d;
  logic [2:0] idx_q;
  logic [6:0] ascii_q;
  logic [8:0] x_q, y_q;
  logic [6:0] char_q   [CHAR_NUM];
  logic [6:0] char_new [CHAR_NUM];
  logic [6:0] colon;

  logic [3:0] hour_t, hour_o, min_t, min_o, sec_t, sec_o;
  logic       hour_oor, min_oor, sec_oor;

  bin2dec_2d #(.MAX(23)) u_hour (
    .bin_i  ({2'b00, hour}),
    .tens_o (hour_t),
    .ones_o (hour_o),
    .oor_o  (hour_oor)
  );

  bin2dec_2d #(.MAX(59)) u_minute (
    .bin_i  ({1'b0, minute}),
    .tens_o (min_t),
    .ones_o (min_o),
    .oor_o  (min_oor)
  );

  bin2dec_2d #(.MAX(59)) u_second (
    .bin_i  ({1'b0, second}),
    .tens_o (sec_t),
    .ones_o (sec_o),
    .oor_o  (sec_oor)
  );

  // Character buffer as it would be captured this cycle; only latched in LOAD.
  always_comb begin
    colon = FONT_COLON;
`ifdef LCD_CLOCK_BLINK_COLON_EN
    if (second[0]) colon = FONT_SPACE;
`endif
    char_new[0] = hour_oor ? FONT_DASH : digit_font(hour_t);
    char_new[1] = hour_oor ? FONT_DASH : digit_font(hour_o);
    char_new[2] = colon;
    char_new[3] = min_oor  ? FONT_DASH : digit_font(min_t);
    char_new[4] = min_oor  ? FONT_DASH : digit_font(min_o);
    char_new[5] = colon;
    char_new[6] = sec_oor  ? FONT_DASH : digit_font(sec_t);
    char_new[7] = sec_oor  ? FONT_DASH : digit_font(sec_o);
  end

  always_comb begin
    state_d            = state_q;
    pending_d          = pending_q;
    busy               = 1'b1;
    frame_done         = 1'b0;
    lcd.show_char_flag = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (refresh_req || pending_q) begin
          state_d   = StLoad;
          pending_d = 1'b0;
        end
      end
      StLoad:  state_d = StIssue;
      StIssue: begin
        lcd.show_char_flag = 1'b1;
        state_d            = StWait;
      end
      StWait:  if (lcd.show_char_done) state_d = StNext;
      // The extra NEXT cycle lets the renderer settle back to idle.
      StNext:  state_d = (idx_q == LastIdx) ? StFdone : StIssue;
      StFdone: begin
        frame_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A frame in progress is never restarted; the request is remembered.
    if (refresh_req && (state_q != StIdle)) pending_d = 1'b1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  // Coordinates and index are loaded ahead of ISSUE so they are valid with
  // the start pulse and held for the renderer's whole operation.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idx_q   <= '0;
      ascii_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      for (int unsigned i = 0; i < CHAR_NUM; i++) char_q[i] <= '0;
    end else if (state_q == StLoad) begin
      char_q  <= char_new;
      idx_q   <= '0;
      ascii_q <= char_new[0];
      x_q     <= X0;
      y_q     <= Y0;
    end else if ((state_q == StNext) && (idx_q != LastIdx)) begin
      idx_q   <= idx_q + 3'd1;
      ascii_q <= char_q[idx_q + 3'd1];
      x_q     <= x_q + Pitch;  // 9-bit wrap is intended
    end
  end

  assign lcd.ascii_num = ascii_q;
  assign lcd.start_x   = x_q;
  assign lcd.start_y   = y_q;
  assign lcd.en_size   = FONT_LARGE;

endmodule
